// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   Each digit is selected for REFRESH_DIV clocks. The first GUARD clocks of
//   every slot keep all anodes off to suppress ghosting. Digit data is latched
//   into shadow registers once per frame so that a frame never tears. Leading
//   zeros can optionally be blanked.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous reset, active-low
//   data        in   4*N_DIGITS hex nibbles; data[3:0] is digit 0 (rightmost)
//   dp_en       in   N_DIGITS decimal-point enables, active-high
//   blank       in   1 = display dark (scan keeps running)
//   seg         out  {a,b,c,d,e,f,g}, active-low, registered
//   dp          out  decimal point, active-low, registered
//   anode       out  N_DIGITS digit selects, active-low, registered
//   frame_start out  one-cycle strobe in the cycle after the shadow load
module seg_scan_driver #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2,
  parameter bit          LZ_BLANK    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     dp_en,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     anode,
  output logic                    frame_start
);

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
    $fatal(1, "seg_scan_driver: N_DIGITS=%0d outside 1..8", N_DIGITS);
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $fatal(1, "seg_scan_driver: REFRESH_DIV=%0d must be >= 2", REFRESH_DIV);
  end
  if (GUARD >= REFRESH_DIV) begin : g_bad_guard
    $fatal(1, "seg_scan_driver: GUARD=%0d must be < REFRESH_DIV", GUARD);
  end

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     anode_q, anode_d;
  logic                    frame_start_q, frame_start_d;

  logic                    cnt_wrap;
  logic                    frame_load;
  logic                    active;
  logic [N_DIGITS-1:0]     lz_sup;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_sup;

  always_comb begin
    cnt_wrap   = (cnt_q == CNT_MAX);
    frame_load = cnt_wrap && (idx_q == IDX_MAX);

    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end

    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (frame_load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp_en;
    end
    frame_start_d = frame_load;

    // Digit k>0 is a leading zero when it and every digit above it are 0.
    lz_sup = '0;
    for (int unsigned k = 1; k < N_DIGITS; k++) begin
      lz_sup[k] = 1'b1;
      for (int unsigned j = k; j < N_DIGITS; j++) begin
        if (shadow_data_q[4*j +: 4] != 4'h0) begin
          lz_sup[k] = 1'b0;
        end
      end
    end

    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = shadow_data_q[4*k +: 4];
        cur_dp  = shadow_dp_q[k];
        cur_sup = lz_sup[k];
      end
    end

    // Dead time and blank share the all-dark output; blank wins over a slot.
    active  = !blank && (cnt_q >= CNT_GUARD);
    anode_d = '1;
    seg_d   = '1;
    dp_d    = 1'b1;
    if (active) begin
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          anode_d[k] = 1'b0;
        end
      end
      seg_d = (LZ_BLANK && cur_sup) ? '1 : decode(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      seg_q         <= '1;
      dp_q          <= 1'b1;
      anode_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      anode_q       <= anode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign anode       = anode_q;
  assign frame_start = frame_start_q;

endmodule
